// File: rtl/v_data_setup.sv
// Purpose: feeds 16-byte ifmap words into per-column FIFOs with a diagonal byte skew,
//          so that a broadcast read of the FIFOs presents a systolic wavefront.
// Latency: column i lags column 0 by i steps. One step per fire. done follows the last fire by 1 cycle.
// Backpressure: no step while any active FIFO is full. The delay lines hold, so no byte is lost or duplicated.
// Optional: define V_SETUP_STALL_CNT_EN to count RUN cycles without a fire on stall_cycles.
module v_data_setup #(
    parameter int LEN_W   = 10,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic [LEN_W-1:0]   num_words,
    output logic               busy,
    output logic               done,
    input  logic [127:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [15:0][7:0]   out_col,
    output logic [15:0]        fifo_WVALID_col,
    input  logic [15:0]        fifo_WREADY_col,
    output logic [STALL_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             pw;         // 1: pointwise (8 columns), 0: depthwise (15 columns)
    logic [LEN_W-1:0] n_lat;
    logic [LEN_W:0]   step;       // one extra bit so N+A-2 never wraps
    logic [LEN_W:0]   n_ext;
    logic [LEN_W:0]   last_step;
    logic [15:0]      act_mask;
    logic             have_word;
    logic             all_rdy;
    logic             fire;
    logic             accept;
    logic [15:0][7:0] stage_in;
    logic [7:0]       col_tap [16];

    assign accept    = (state == IDLE) && start && (mode == 2'd1 || mode == 2'd2);
    assign n_ext     = {1'b0, n_lat};
    // The last step is N+A-2, which is N+6 for pointwise and N+13 for depthwise.
    assign last_step = n_ext + (pw ? (LEN_W+1)'(6) : (LEN_W+1)'(13));
    assign act_mask  = pw ? 16'h00FF : 16'h7FFF;
    assign have_word = step < n_ext;
    // WREADY is a registered not-full flag, so the strobes can depend on it combinationally.
    assign all_rdy   = &(fifo_WREADY_col | ~act_mask);
    assign fire      = (state == RUN) && all_rdy && (!have_word || in_valid);
    assign in_ready  = (state == RUN) && all_rdy && have_word;
    assign fifo_WVALID_col = fire ? act_mask : 16'h0000;

    // Once all N words are consumed, zeros are fed in to flush the skew tail.
    always_comb begin
        stage_in = '0;
        for (int i = 0; i < 16; i++) begin
            stage_in[i] = have_word ? in_data[8*i +: 8] : 8'h00;
        end
    end

    assign col_tap[0] = stage_in[0];

    generate
        for (genvar c = 1; c < 16; c++) begin : g_skew
            logic [7:0] dly [0:c-1];
            // Shift one byte per fire. Clear on reset and on every accepted start.
            always_ff @(posedge clk) begin
                if (rst || accept) begin
                    for (int k = 0; k < c; k++) dly[k] <= 8'h00;
                end else if (fire) begin
                    dly[0] <= stage_in[c];
                    for (int k = 1; k < c; k++) dly[k] <= dly[k-1];
                end
            end
            assign col_tap[c] = dly[c-1];
        end
    endgenerate

    // Drive a column byte only when it is actually written. Otherwise drive zero.
    always_comb begin
        out_col = '0;
        for (int i = 0; i < 16; i++) begin
            out_col[i] = (fire && act_mask[i]) ? col_tap[i] : 8'h00;
        end
    end

    // Transfer control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            step  <= '0;
            pw    <= 1'b0;
            n_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        pw    <= (mode == 2'd2);
                        n_lat <= num_words;
                        step  <= '0;
                        if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        step <= step + 1'b1;
                        if (step == last_step) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef V_SETUP_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    // Count RUN cycles without a fire. Saturate, and hold outside RUN.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_q <= '0;
        end else if (state == RUN && !fire && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_v_data_setup.sv
module tb_v_data_setup;
    localparam int LEN_W   = 10;
    localparam int STALL_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mode;
    logic               start;
    logic [LEN_W-1:0]   num_words;
    logic               busy;
    logic               done;
    logic [127:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic [15:0][7:0]   out_col;
    logic [15:0]        wvalid;
    logic [15:0]        wready;
    logic [STALL_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    v_data_setup #(.LEN_W(LEN_W), .STALL_W(STALL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .start           (start),
        .num_words       (num_words),
        .busy            (busy),
        .done            (done),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_col         (out_col),
        .fifo_WVALID_col (wvalid),
        .fifo_WREADY_col (wready),
        .stall_cycles    (stall_cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] words [$];
    logic [7:0]   cap [16][$];
    int fires, stalls, proto_bad, last_fire_cyc, done_cyc;

    // Reference: entry k of column c is byte c of word (k-c) when that word exists, else zero.
    function automatic logic [7:0] model_byte(int c, int k, int n);
        int w;
        w = k - c;
        if (w >= 0 && w < n) return words[w][8*c +: 8];
        return 8'h00;
    endfunction

    function automatic int act_cols(int md);
        return (md == 1) ? 15 : 8;
    endfunction

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Runs one transfer and records every column write. Protocol slips are counted in proto_bad.
    task automatic run_xfer(input int md, input int n, input int drop_col, input int drop_at,
                            input int drop_len, input int gap_at, input int gap_len,
                            input bit rnd_iv, input int restart_at);
        int a, widx, s_pre, drop_rem, gap_rem, budget;
        bit drop_used, gap_used, restarted, exp_fire, exp_ir, iv;
        logic [15:0] wv;
        logic [15:0][7:0] oc;
        logic ir;
        a = act_cols(md);
        widx = 0; fires = 0; stalls = 0; proto_bad = 0; last_fire_cyc = -1; done_cyc = -1;
        drop_rem = 0; gap_rem = 0; drop_used = 0; gap_used = 0; restarted = 0;
        budget = n + a + 200;
        for (int c = 0; c < 16; c++) cap[c].delete();
        @(negedge clk);
        mode = 2'(md); num_words = LEN_W'(n); start = 1'b1; in_valid = 1'b0; wready = '1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            mode = 2'($urandom);
            num_words = LEN_W'($urandom);
            if (!drop_used && drop_len > 0 && fires == drop_at) begin drop_rem = drop_len; drop_used = 1; end
            if (!gap_used && gap_len > 0 && fires == gap_at) begin gap_rem = gap_len; gap_used = 1; end
            wready = 16'($urandom);
            for (int c = 0; c < a; c++) wready[c] = 1'b1;
            if (drop_rem > 0) wready[drop_col] = 1'b0;
            iv = (widx < n) && (gap_rem == 0) && (!rnd_iv || $urandom_range(0, 3) != 0);
            in_valid = iv;
            in_data = (widx < n) ? words[widx] : {$urandom, $urandom, $urandom, $urandom};
            start = 1'b0;
            if (restart_at >= 0 && !restarted && fires == restart_at) begin
                start = 1'b1; mode = (md == 1) ? 2'd2 : 2'd1; num_words = LEN_W'(n + 3); restarted = 1;
            end
            #1;
            wv = wvalid; oc = out_col; ir = in_ready;
            if (done) begin
                done_cyc = cyc;
                if (busy) proto_bad++;
                break;
            end
            if (!busy) proto_bad++;
            s_pre = fires;
            exp_fire = (drop_rem == 0) && (s_pre >= n || iv);
            exp_ir = (drop_rem == 0) && (s_pre < n);
            if (ir !== exp_ir) proto_bad++;
            if (wv[0] !== exp_fire) proto_bad++;
            for (int c = 0; c < 16; c++) begin
                if (c < a) begin
                    if (wv[c] !== wv[0]) proto_bad++;
                    if (wv[c]) cap[c].push_back(oc[c]);
                end else if (wv[c] !== 1'b0) proto_bad++;
                if (!wv[c] && oc[c] !== 8'h00) proto_bad++;
            end
            if (wv[0]) begin fires++; last_fire_cyc = cyc; end
            else stalls++;
            if (ir && iv) widx++;
            if (drop_rem > 0) drop_rem--;
            if (gap_rem > 0) gap_rem--;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; wready = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 2'd1; num_words = 10'd5; in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom}; wready = '1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b, required 0", done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        n_cmp++; if (wvalid !== 16'h0) begin n_bad++; $display("FAIL rst_wvalid: got %h, required 0", wvalid); end
        n_cmp++; if (out_col !== '0) begin n_bad++; $display("FAIL rst_out_col: got %h, required 0", out_col); end
        n_cmp++; if (stall_cycles !== '0) begin n_bad++; $display("FAIL rst_stall: got %0d, required 0", stall_cycles); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_depthwise();
        logic [127:0] w0, w1;
        int n, a;
        n = 2; a = 15;
        for (int i = 0; i < 16; i++) begin w0[8*i +: 8] = 8'(i); w1[8*i +: 8] = 8'(16 + i); end
        words.delete(); words.push_back(w0); words.push_back(w1);
        run_xfer(1, n, 0, -1, 0, -1, 0, 0, -1);
        n_cmp++; if (fires !== 16) begin n_bad++; $display("FAIL dw_fires: got %0d, required 16", fires); end
        n_cmp++; if (done_cyc !== last_fire_cyc + 1) begin n_bad++; $display("FAIL dw_done: done at %0d, required %0d", done_cyc, last_fire_cyc + 1); end
        n_cmp++; if (proto_bad !== 0) begin n_bad++; $display("FAIL dw_protocol: got %0d errors, required 0", proto_bad); end
        n_cmp++;
        if (cap[0].size() < 2 || cap[0][1] !== 8'h10) begin n_bad++; $display("FAIL dw_col0_w1: got %0d entries, required byte 10 at idx 1", cap[0].size()); end
        n_cmp++;
        if (cap[14].size() != 16 || cap[14][14] !== 8'h0E || cap[14][15] !== 8'h1E) begin
            n_bad++; $display("FAIL dw_col14_tail: got %0d entries, required 16 ending 0E,1E", cap[14].size());
        end
        for (int c = 0; c < 16; c++) begin
            int ne, bad;
            ne = (c < a) ? n + a - 1 : 0;
            bad = (cap[c].size() == ne) ? -1 : 0;
            for (int k = 0; k < ne && bad < 0; k++) if (cap[c][k] !== model_byte(c, k, n)) bad = k;
            n_cmp++;
            if (bad >= 0) begin n_bad++; $display("FAIL dw_col%0d: %0d entries (bad at %0d), required %0d", c, cap[c].size(), bad, ne); end
        end
    endtask

    task automatic test_pointwise();
        int n, a;
        n = 3; a = 8;
        fill_words(n);
        run_xfer(2, n, 0, -1, 0, -1, 0, 0, -1);
        n_cmp++; if (fires !== 10) begin n_bad++; $display("FAIL pw_fires: got %0d, required 10", fires); end
        n_cmp++; if (done_cyc !== last_fire_cyc + 1) begin n_bad++; $display("FAIL pw_done: done at %0d, required %0d", done_cyc, last_fire_cyc + 1); end
        n_cmp++; if (proto_bad !== 0) begin n_bad++; $display("FAIL pw_protocol: got %0d errors, required 0", proto_bad); end
        for (int c = 0; c < 16; c++) begin
            int ne, bad;
            ne = (c < a) ? n + a - 1 : 0;
            bad = (cap[c].size() == ne) ? -1 : 0;
            for (int k = 0; k < ne && bad < 0; k++) if (cap[c][k] !== model_byte(c, k, n)) bad = k;
            n_cmp++;
            if (bad >= 0) begin n_bad++; $display("FAIL pw_col%0d: %0d entries (bad at %0d), required %0d", c, cap[c].size(), bad, ne); end
        end
    endtask

    task automatic test_backpressure();
        int n, a;
        n = 4; a = 8;
        fill_words(n);
        run_xfer(2, n, 3, 2, 5, -1, 0, 0, -1);
        n_cmp++; if (fires !== n + a - 1) begin n_bad++; $display("FAIL bp_fires: got %0d, required %0d", fires, n + a - 1); end
        n_cmp++; if (stalls !== 5) begin n_bad++; $display("FAIL bp_stalls: got %0d, required 5", stalls); end
        n_cmp++; if (proto_bad !== 0) begin n_bad++; $display("FAIL bp_protocol: got %0d errors, required 0", proto_bad); end
        n_cmp++; if (done_cyc !== last_fire_cyc + 1) begin n_bad++; $display("FAIL bp_done: done at %0d, required %0d", done_cyc, last_fire_cyc + 1); end
`ifdef V_SETUP_STALL_CNT_EN
        n_cmp++; if (stall_cycles !== 16'd5) begin n_bad++; $display("FAIL bp_stall_cnt: got %0d, required 5", stall_cycles); end
`endif
        for (int c = 0; c < 16; c++) begin
            int ne, bad;
            ne = (c < a) ? n + a - 1 : 0;
            bad = (cap[c].size() == ne) ? -1 : 0;
            for (int k = 0; k < ne && bad < 0; k++) if (cap[c][k] !== model_byte(c, k, n)) bad = k;
            n_cmp++;
            if (bad >= 0) begin n_bad++; $display("FAIL bp_col%0d: %0d entries (bad at %0d), required %0d", c, cap[c].size(), bad, ne); end
        end
    endtask

    task automatic test_source_stall();
        int n, a;
        n = 3; a = 15;
        fill_words(n);
        run_xfer(1, n, 0, -1, 0, 1, 3, 0, -1);
        n_cmp++; if (fires !== n + a - 1) begin n_bad++; $display("FAIL ss_fires: got %0d, required %0d", fires, n + a - 1); end
        n_cmp++; if (stalls !== 3) begin n_bad++; $display("FAIL ss_stalls: got %0d, required 3", stalls); end
        n_cmp++; if (proto_bad !== 0) begin n_bad++; $display("FAIL ss_protocol: got %0d errors, required 0", proto_bad); end
`ifdef V_SETUP_STALL_CNT_EN
        n_cmp++; if (stall_cycles !== 16'd3) begin n_bad++; $display("FAIL ss_stall_cnt: got %0d, required 3", stall_cycles); end
`endif
        for (int c = 0; c < 16; c++) begin
            int ne, bad;
            ne = (c < a) ? n + a - 1 : 0;
            bad = (cap[c].size() == ne) ? -1 : 0;
            for (int k = 0; k < ne && bad < 0; k++) if (cap[c][k] !== model_byte(c, k, n)) bad = k;
            n_cmp++;
            if (bad >= 0) begin n_bad++; $display("FAIL ss_col%0d: %0d entries (bad at %0d), required %0d", c, cap[c].size(), bad, ne); end
        end
    endtask

    task automatic test_control();
        int bad, n, a;
        // An empty transfer goes straight to DONE.
        @(negedge clk);
        mode = 2'd2; num_words = '0; start = 1'b1; wready = '1; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL n0_done: got %b, required 1", done); end
        n_cmp++; if (busy !== 1'b0 || wvalid !== 16'h0) begin n_bad++; $display("FAIL n0_idle: busy %b wvalid %h, required 0/0", busy, wvalid); end
        @(negedge clk);
        #1;
        n_cmp++; if (done !== 1'b0 || wvalid !== 16'h0) begin n_bad++; $display("FAIL n0_pulse: done %b wvalid %h, required 0/0", done, wvalid); end
        in_valid = 1'b0;
        // Idle and reserved modes are ignored.
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            mode = (m == 0) ? 2'd0 : 2'd3; num_words = 10'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            bad = 0;
            repeat (3) begin
                #1;
                if (busy || done || wvalid != 16'h0) bad++;
                @(negedge clk);
            end
            n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL mode%0d_ignored: got %0d active cycles, required 0", (m == 0) ? 0 : 3, bad); end
        end
        // A second start during RUN is ignored.
        n = 3; a = 8;
        fill_words(n);
        run_xfer(2, n, 0, -1, 0, -1, 0, 0, 1);
        n_cmp++; if (fires !== n + a - 1) begin n_bad++; $display("FAIL rs_fires: got %0d, required %0d", fires, n + a - 1); end
        n_cmp++; if (proto_bad !== 0) begin n_bad++; $display("FAIL rs_protocol: got %0d errors, required 0", proto_bad); end
        for (int c = 0; c < 16; c++) begin
            int ne, bk;
            ne = (c < a) ? n + a - 1 : 0;
            bk = (cap[c].size() == ne) ? -1 : 0;
            for (int k = 0; k < ne && bk < 0; k++) if (cap[c][k] !== model_byte(c, k, n)) bk = k;
            n_cmp++;
            if (bk >= 0) begin n_bad++; $display("FAIL rs_col%0d: %0d entries (bad at %0d), required %0d", c, cap[c].size(), bk, ne); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rs_after_done: done %b busy %b, required 0/0", done, busy); end
    endtask

    task automatic test_max_n();
        int n, a, bad;
        n = 1023; a = 8;
        fill_words(n);
        run_xfer(2, n, 0, -1, 0, -1, 0, 0, -1);
        n_cmp++; if (fires !== n + a - 1) begin n_bad++; $display("FAIL max_fires: got %0d, required %0d", fires, n + a - 1); end
        n_cmp++; if (done_cyc !== last_fire_cyc + 1) begin n_bad++; $display("FAIL max_done: done at %0d, required %0d", done_cyc, last_fire_cyc + 1); end
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (cap[c].size() != ((c < a) ? n + a - 1 : 0)) bad++;
            else for (int k = 0; k < cap[c].size(); k++) if (cap[c][k] !== model_byte(c, k, n)) bad++;
        end
        n_cmp++; if (bad !== 0 || proto_bad !== 0) begin n_bad++; $display("FAIL max_data: got %0d bad entries and %0d protocol errors, required 0", bad, proto_bad); end
    endtask

    task automatic test_reset_mid();
        int f, n, a;
        fill_words(8);
        @(negedge clk);
        mode = 2'd1; num_words = 10'd8; start = 1'b1; in_valid = 1'b1; wready = '1;
        @(negedge clk);
        start = 1'b0;
        f = 0;
        for (int cyc = 0; cyc < 50 && f < 5; cyc++) begin
            in_data = words[f];
            #1;
            if (wvalid[0]) f++;
            @(negedge clk);
        end
        n_cmp++; if (f !== 5) begin n_bad++; $display("FAIL rm_reach: got %0d fires, required 5", f); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rm_busy: busy %b done %b, required 0/0", busy, done); end
        n_cmp++; if (wvalid !== 16'h0 || out_col !== '0) begin n_bad++; $display("FAIL rm_outputs: wvalid %h, required 0", wvalid); end
        rst = 1'b0; in_valid = 1'b0;
        n = 1; a = 15;
        fill_words(n);
        run_xfer(1, n, 0, -1, 0, -1, 0, 0, -1);
        n_cmp++; if (fires !== n + a - 1 || proto_bad !== 0) begin n_bad++; $display("FAIL rm_rerun: got %0d fires / %0d errors, required %0d / 0", fires, proto_bad, n + a - 1); end
        for (int c = 0; c < 16; c++) begin
            int ne, bad;
            ne = (c < a) ? n + a - 1 : 0;
            bad = (cap[c].size() == ne) ? -1 : 0;
            for (int k = 0; k < ne && bad < 0; k++) if (cap[c][k] !== model_byte(c, k, n)) bad = k;
            n_cmp++;
            if (bad >= 0) begin n_bad++; $display("FAIL rm_col%0d: %0d entries (bad at %0d), required %0d", c, cap[c].size(), bad, ne); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int md, n, a, dc, da, dl, rs, bad;
            md = $urandom_range(1, 2);
            n = $urandom_range(1, 24);
            a = act_cols(md);
            dc = $urandom_range(0, a - 1);
            da = $urandom_range(0, n + a - 2);
            dl = $urandom_range(0, 4);
            rs = $urandom_range(0, n + a - 3);
            fill_words(n);
            run_xfer(md, n, dc, da, dl, -1, 0, 1, rs);
            n_cmp++; if (fires !== n + a - 1) begin n_bad++; $display("FAIL rnd%0d_fires: got %0d, required %0d", it, fires, n + a - 1); end
            n_cmp++; if (done_cyc !== last_fire_cyc + 1) begin n_bad++; $display("FAIL rnd%0d_done: done at %0d, required %0d", it, done_cyc, last_fire_cyc + 1); end
`ifdef V_SETUP_STALL_CNT_EN
            n_cmp++; if (stall_cycles !== 16'(stalls)) begin n_bad++; $display("FAIL rnd%0d_stall_cnt: got %0d, required %0d", it, stall_cycles, stalls); end
`endif
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                if (cap[c].size() != ((c < a) ? n + a - 1 : 0)) bad++;
                else for (int k = 0; k < cap[c].size(); k++) if (cap[c][k] !== model_byte(c, k, n)) bad++;
            end
            n_cmp++; if (bad !== 0 || proto_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_data: got %0d bad entries and %0d protocol errors, required 0", it, bad, proto_bad); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; num_words = '0;
        in_data = '0; in_valid = 1'b0; wready = '1;
        test_reset();
        test_depthwise();
        test_pointwise();
        test_backpressure();
        test_source_stall();
        test_control();
        test_max_n();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
